// File: rtl/booth_seq_ctrl.sv
// rtl/booth_seq_ctrl.sv - radix-4 Booth sequencing controller with valid/ready operand and product handshakes
module booth_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic [2:0]           booth_grp,
   output logic                 busy
);

   localparam int PW = 2 * WIDTH;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Index of the final Booth group; the edge that consumes it ends RUN.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH / 2 - 1);

   logic [1:0]        r_state;
   logic [WIDTH-1:0]  r_m;
   // Multiplier stored with the implicit Y[-1]=0 appended as bit 0.
   logic [WIDTH:0]    r_y;
   logic [PW-1:0]     r_acc;
   logic [CNT_W-1:0]  r_cnt;
   logic [PW-1:0]     r_product;
   logic              r_out_valid;

   logic              w_accept;
   logic              w_release;
   logic              w_last;
   logic [CNT_W:0]    w_shamt;
   logic [2:0]        w_grp;
   logic [PW-1:0]     w_m_ext;
   logic [PW-1:0]     w_m2;
   logic [PW-1:0]     w_pp;
   logic [PW-1:0]     w_pp_sh;
   logic [PW-1:0]     w_acc_next;

   assign w_accept  = in_valid && (r_state == S_IDLE);
   assign w_release = r_out_valid && out_ready && (r_state == S_DONE);
   assign w_last    = (r_cnt == LAST_CNT);

   // Group cnt sits at bits [2*cnt+1 : 2*cnt-1] of Y, i.e. [2*cnt+2 : 2*cnt] of r_y.
   assign w_shamt = {r_cnt, 1'b0};
   assign w_grp   = 3'(r_y >> w_shamt);

   // Multiples are built at full product width so that negating the most
   // negative multiplicand (and twice it) cannot overflow.
   assign w_m_ext = {{WIDTH{r_m[WIDTH-1]}}, r_m};
   assign w_m2    = w_m_ext << 1;

   // Booth digit selection: {0, +M, +2M, -2M, -M}.
   always_comb begin
      w_pp = '0;
      case (w_grp)
         3'b001, 3'b010: w_pp = w_m_ext;
         3'b011:         w_pp = w_m2;
         3'b100:         w_pp = -w_m2;
         3'b101, 3'b110: w_pp = -w_m_ext;
         default:        w_pp = '0;
      endcase
   end

   assign w_pp_sh    = w_pp << w_shamt;
   assign w_acc_next = r_acc + w_pp_sh;

   // Control state machine: accept in IDLE, step groups in RUN, hold in DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (w_accept)  r_state <= S_RUN;
            S_RUN:   if (w_last)    r_state <= S_DONE;
            S_DONE:  if (w_release) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Operand capture happens only on the accept edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m <= '0;
         r_y <= '0;
      end else if (w_accept) begin
         r_m <= multiplicand;
         r_y <= {multiplier, 1'b0};
      end
   end

   // Accumulator and group counter advance once per RUN cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (r_state == S_RUN) begin
         r_acc <= w_acc_next;
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Result register and output-valid flag; the product persists past the handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_product   <= '0;
         r_out_valid <= 1'b0;
      end else if ((r_state == S_RUN) && w_last) begin
         r_product   <= w_acc_next;
         r_out_valid <= 1'b1;
      end else if (w_release) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
   assign out_valid = r_out_valid;
   assign product   = r_product;
   assign booth_grp = (r_state == S_RUN) ? w_grp : 3'b000;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb/tb_booth_seq_ctrl.sv - randomized self-checking bench for booth_seq_ctrl
module tb_booth_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  multiplicand;
   logic [7:0]  multiplier;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;
   logic [2:0]  booth_grp;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   booth_seq_ctrl #(.WIDTH(8), .CNT_W(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product),
      .booth_grp    (booth_grp),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: exact signed product truncated to 16 bits.
   function automatic logic [15:0] ref_product(input logic [7:0] a, input logic [7:0] b);
      logic signed [7:0] sa;
      logic signed [7:0] sb;
      int p;
      sa = a;
      sb = b;
      p = int'(sa) * int'(sb);
      return p[15:0];
   endfunction

   // Reference: Booth group k is {Y[2k+1], Y[2k], Y[2k-1]} with Y[-1]=0.
   function automatic logic [2:0] ref_grp(input logic [7:0] b, input int k);
      logic [8:0] yx;
      yx = {b, 1'b0};
      return {yx[2*k+2], yx[2*k+1], yx[2*k]};
   endfunction

   // One full operation: accept, four RUN cycles (with ignored noise on the
   // operand port), then optional backpressure before the product handshake.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall);
      logic [15:0] exp_p;
      exp_p = ref_product(a, b);
      @(negedge clk);
      check("in_ready_idle", 32'(in_ready), 32'd1);
      check("busy_idle", 32'(busy), 32'd0);
      check("grp_idle", 32'(booth_grp), 32'd0);
      in_valid     = 1'b1;
      multiplicand = a;
      multiplier   = b;
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("grp%0d", k), 32'(booth_grp), 32'(ref_grp(b, k)));
         check("out_valid_run", 32'(out_valid), 32'd0);
         check("in_ready_run", 32'(in_ready), 32'd0);
         check("busy_run", 32'(busy), 32'd1);
         in_valid     = (k < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
         multiplicand = 8'($urandom);
         multiplier   = 8'($urandom);
      end
      @(posedge clk);
      for (int s = 0; s <= stall; s++) begin
         @(negedge clk);
         check("out_valid_done", 32'(out_valid), 32'd1);
         check("product", 32'(product), 32'(exp_p));
         check("in_ready_done", 32'(in_ready), 32'd0);
         check("busy_done", 32'(busy), 32'd1);
         if (s == stall) out_ready = 1'b1;
         else            out_ready = 1'b0;
         @(posedge clk);
      end
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_drop", 32'(out_valid), 32'd0);
      check("in_ready_back", 32'(in_ready), 32'd1);
      check("product_held", 32'(product), 32'(exp_p));
   endtask

   initial begin
      rst          = 1'b1;
      in_valid     = 1'b0;
      out_ready    = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_product", 32'(product), 32'd0);
      check("rst_grp", 32'(booth_grp), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op(8'hC1, 8'd5, 0);
      check("basic_val", 32'(product), 32'h0000FEC5);
      run_op(8'h80, 8'h80, 0);
      check("ext_nn", 32'(product), 32'h00004000);
      run_op(8'h7F, 8'h80, 0);
      run_op(8'h80, 8'h7F, 0);
      run_op(8'hFF, 8'hFF, 0);
      run_op(8'h00, 8'hC1, 0);
      run_op(8'hC1, 8'h01, 0);
      run_op(8'd20, 8'hC1, 0);
      check("twenty_val", 32'(product), 32'h0000FB14);
      run_op(8'hC1, 8'd5, 10);

      for (int i = 0; i < 40; i++) begin
         run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
      end

      // Reset two edges into RUN discards the operation.
      @(negedge clk);
      in_valid     = 1'b1;
      multiplicand = 8'h55;
      multiplier   = 8'h33;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_product", 32'(product), 32'd0);
      check("mid_rst_grp", 32'(booth_grp), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("no_stale_valid", 32'(out_valid), 32'd0);
      end
      run_op(8'd7, 8'hF7, 0);
      check("post_rst_val", 32'(product), 32'h0000FFC1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
